// File: rtl/fxp8s_array_arbiter_pkg.sv
// Shared types and constants for the two-requester FXP8S PE-array arbiter.
package fxp8s_array_arbiter_pkg;
   localparam int NUM_REQ     = 2;
   localparam int FXP8S_W     = 8;
   localparam int BEATS_3X3   = 9;
   localparam int CNT_W       = 4;
   localparam int FLUSH_CNT_W = 3;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_DRAIN = 2'd2,
      ST_FLUSH = 2'd3
   } state_t;
endpackage

// File: rtl/fxp8s_array_arbiter_if.sv
// Requester-side and PE-array-side streams; master is the arbiter view, slave the environment view.
interface fxp8s_array_arbiter_if;
   import fxp8s_array_arbiter_pkg::*;

   logic [NUM_REQ-1:0]         req_en_in_data;
   logic [NUM_REQ-1:0]         req_rdy_in_data;
   logic [NUM_REQ-1:0]         req_in_mat;
   logic [NUM_REQ-1:0]         req_in_new_row;
   logic [NUM_REQ-1:0]         req_in_mat_done;
   logic [NUM_REQ*FXP8S_W-1:0] req_in_data;
   logic [NUM_REQ-1:0]         req_en_out_data;
   logic [NUM_REQ-1:0]         req_rdy_out_data;
   logic [FXP8S_W-1:0]         req_out_data;

   logic                       arr_rstn;
   logic                       arr_en_in_data;
   logic                       arr_in_mat;
   logic                       arr_in_new_row;
   logic                       arr_in_mat_done;
   logic [FXP8S_W-1:0]         arr_in_data;
   logic                       arr_rdy_in_data;
   logic                       arr_en_out_data;
   logic [FXP8S_W-1:0]         arr_out_data;
   logic                       arr_rdy_out_data;

   modport master (
      input  req_en_in_data, req_in_mat, req_in_new_row, req_in_mat_done, req_in_data,
      input  req_rdy_out_data, arr_rdy_in_data, arr_en_out_data, arr_out_data,
      output req_rdy_in_data, req_en_out_data, req_out_data,
      output arr_rstn, arr_en_in_data, arr_in_mat, arr_in_new_row, arr_in_mat_done,
      output arr_in_data, arr_rdy_out_data
   );

   modport slave (
      output req_en_in_data, req_in_mat, req_in_new_row, req_in_mat_done, req_in_data,
      output req_rdy_out_data, arr_rdy_in_data, arr_en_out_data, arr_out_data,
      input  req_rdy_in_data, req_en_out_data, req_out_data,
      input  arr_rstn, arr_en_in_data, arr_in_mat, arr_in_new_row, arr_in_mat_done,
      input  arr_in_data, arr_rdy_out_data
   );
endinterface

// File: rtl/fxp8s_array_arbiter_rr_arb2.sv
// Two-way round-robin picker: the pointer names the favoured requester and
// moves to the other one whenever a job completes.
module fxp8s_rr_arb2 (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic       upd,
   input  logic       owner,
   output logic [1:0] pick
);
   logic ptr;
   logic alt;

   assign alt = ~ptr;

   always_ff @(posedge clk) begin
      if (rst)
         ptr <= 1'b0;
      else if (upd)
         ptr <= ~owner;
   end

   always_comb begin
      pick = 2'b00;
      if (req[ptr])
         pick[ptr] = 1'b1;
      else if (req[alt])
         pick[alt] = 1'b1;
   end
endmodule

// File: rtl/fxp8s_array_arbiter.sv
// Lends one PE array to two requesters: load the operand stream, drain OUT_BEATS
// results back to the owner, then hold the array in reset for FLUSH_CYCLES.
module fxp8s_array_arbiter
   import fxp8s_array_arbiter_pkg::*;
#(
   parameter int OUT_BEATS    = BEATS_3X3,
   parameter int FLUSH_CYCLES = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   fxp8s_array_arbiter_if.master bus,
   output logic [NUM_REQ-1:0]   grant,
   output logic [NUM_REQ-1:0]   job_done
);
   state_t                 state;
   state_t                 state_nxt;
   logic [CNT_W-1:0]       beat_cnt;
   logic [FLUSH_CNT_W-1:0] flush_cnt;
   logic [NUM_REQ-1:0]     pick;
   logic                   gidx;
   logic                   out_fire;
   logic                   last_beat;
   logic                   flush_end;
   logic                   any_req;

   assign gidx      = grant[1];
   assign any_req   = |bus.req_en_in_data;
   assign out_fire  = (state == ST_DRAIN) && bus.arr_en_out_data && bus.req_rdy_out_data[gidx];
   assign last_beat = out_fire && (beat_cnt == CNT_W'(OUT_BEATS - 1));
   assign flush_end = (state == ST_FLUSH) && (flush_cnt == FLUSH_CNT_W'(FLUSH_CYCLES - 1));

   fxp8s_rr_arb2 u_rr (
      .clk   (clk),
      .rst   (rst),
      .req   (bus.req_en_in_data),
      .upd   (last_beat),
      .owner (gidx),
      .pick  (pick)
   );

   always_ff @(posedge clk) begin
      if (rst)
         state <= ST_IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (any_req)              state_nxt = ST_LOAD;
         ST_LOAD:  if (bus.arr_en_out_data)  state_nxt = ST_DRAIN;
         ST_DRAIN: if (last_beat)            state_nxt = ST_FLUSH;
         ST_FLUSH: if (flush_end)            state_nxt = ST_IDLE;
         default:                            state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         grant     <= '0;
         job_done  <= '0;
         beat_cnt  <= '0;
         flush_cnt <= '0;
      end else begin
         job_done <= last_beat ? grant : '0;
         if (state == ST_IDLE && any_req)
            grant <= pick;
         else if (flush_end)
            grant <= '0;
         if (state == ST_LOAD && bus.arr_en_out_data)
            beat_cnt <= '0;
         else if (out_fire)
            beat_cnt <= beat_cnt + CNT_W'(1);
         flush_cnt <= (state == ST_FLUSH) ? flush_cnt + FLUSH_CNT_W'(1) : '0;
      end
   end

   always_comb begin
      bus.req_rdy_in_data  = '0;
      bus.req_en_out_data  = '0;
      bus.req_out_data     = bus.arr_out_data;
      bus.arr_en_in_data   = 1'b0;
      bus.arr_in_mat       = 1'b0;
      bus.arr_in_new_row   = 1'b0;
      bus.arr_in_mat_done  = 1'b0;
      bus.arr_in_data      = '0;
      bus.arr_rdy_out_data = 1'b0;
      bus.arr_rstn         = !rst && (state != ST_FLUSH);
      case (state)
         ST_LOAD: begin
            // Once the array starts answering, the operand stream is closed off.
            if (!bus.arr_en_out_data) begin
               bus.arr_en_in_data        = bus.req_en_in_data[gidx];
               bus.arr_in_mat            = bus.req_in_mat[gidx];
               bus.arr_in_new_row        = bus.req_in_new_row[gidx];
               bus.arr_in_mat_done       = bus.req_in_mat_done[gidx];
               bus.arr_in_data           = bus.req_in_data[gidx*FXP8S_W +: FXP8S_W];
               bus.req_rdy_in_data[gidx] = bus.arr_rdy_in_data;
            end
         end
         ST_DRAIN: begin
            bus.req_en_out_data[gidx] = bus.arr_en_out_data;
            bus.arr_rdy_out_data      = bus.req_rdy_out_data[gidx];
         end
         default: ;
      endcase
   end
endmodule

// File: tb/tb_fxp8s_array_arbiter.sv
// Directed bench: the bench plays both requesters and the PE array; result bytes go through a scoreboard queue.
module tb_fxp8s_array_arbiter;
   import fxp8s_array_arbiter_pkg::*;

   localparam int OUT = 9;
   localparam int NIN = 18;

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] grant;
   logic [1:0] job_done;

   fxp8s_array_arbiter_if bus ();

   fxp8s_array_arbiter #(.OUT_BEATS(OUT), .FLUSH_CYCLES(2)) dut (
      .clk      (clk),
      .rst      (rst),
      .bus      (bus.master),
      .grant    (grant),
      .job_done (job_done)
   );

   always #5 clk = ~clk;

   int         checks = 0;
   int         errors = 0;
   int         jobn   = 0;
   logic [7:0] sb[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
      checks++;
      assert (obs === want) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
      end
   endtask

   function automatic logic [1:0] oh(input int r);
      return 2'(1 << r);
   endfunction

   function automatic logic [7:0] din(input int r, input int k);
      return 8'(r * 64 + k * 5 + 1);
   endfunction

   function automatic logic [7:0] dout(input int r, input int j);
      return 8'(jobn * 37 + r * 91 + j * 11 + 7);
   endfunction

   task automatic adv();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   task automatic drive_in(input int r, input int k);
      bus.req_in_data[r*8 +: 8]  = din(r, k);
      bus.req_in_mat[r]          = (k >= NIN / 2);
      bus.req_in_new_row[r]      = (k % 3 == 0);
      bus.req_in_mat_done[r]     = (k == NIN - 1);
   endtask

   task automatic drive_req(input logic [1:0] who);
      for (int r = 0; r < 2; r++) begin
         if (who[r]) begin
            drive_in(r, 0);
            bus.req_en_in_data[r] = 1'b1;
         end
      end
   endtask

   task automatic raise(input logic [1:0] who);
      adv();
      drive_req(who);
      smp();
   endtask

   task automatic wait_grant(input int r, output int cyc);
      cyc = 0;
      do begin
         adv();
         smp();
         cyc++;
      end while (grant !== oh(r) && cyc < 40);
      chk("grant", grant, oh(r));
   endtask

   task automatic load(input int r);
      for (int k = 0; k < NIN; k++) begin
         chk("in_en", bus.arr_en_in_data, 1);
         chk("in_dat", bus.arr_in_data, din(r, k));
         chk("in_side", {bus.arr_in_mat, bus.arr_in_new_row, bus.arr_in_mat_done},
             {k >= NIN / 2, k % 3 == 0, k == NIN - 1});
         chk("in_rdy", bus.req_rdy_in_data, oh(r));
         adv();
         if (k < NIN - 1) drive_in(r, k + 1);
         else bus.req_en_in_data[r] = 1'b0;
         smp();
      end
      chk("in_en_end", bus.arr_en_in_data, 0);
   endtask

   task automatic drain(input int r, input int stall_at, input int stall_len, input int rst_at);
      int b, cyc, st;
      logic af, rf;
      logic [7:0] want;
      b = 0; cyc = 0; st = 0;
      jobn++;
      adv();
      bus.arr_en_out_data     = 1'b1;
      bus.arr_out_data        = dout(r, 0);
      sb.push_back(dout(r, 0));
      bus.req_rdy_out_data[r] = 1'b1;
      smp();
      chk("load_no_out", bus.req_en_out_data, 0);
      chk("load_no_ardy", bus.arr_rdy_out_data, 0);
      adv();
      smp();
      while (b < OUT && cyc < 80) begin
         af = bus.arr_en_out_data && bus.arr_rdy_out_data;
         rf = bus.req_en_out_data[r] && bus.req_rdy_out_data[r];
         chk("hs_agree", rf, af);
         chk("en_out", bus.req_en_out_data, oh(r));
         chk("rstn_drain", bus.arr_rstn, 1);
         chk("jd_drain", job_done, 0);
         chk("rdy_in_drain", bus.req_rdy_in_data, 0);
         if (rf) begin
            want = (sb.size() > 0) ? sb.pop_front() : 8'hxx;
            chk("out_dat", bus.req_out_data, want);
         end
         adv();
         cyc++;
         if (af) begin
            b++;
            if (b < OUT) begin
               bus.arr_out_data = dout(r, b);
               sb.push_back(dout(r, b));
            end else begin
               bus.arr_en_out_data = 1'b0;
            end
         end
         if (b == stall_at && st < stall_len) begin
            bus.req_rdy_out_data[r] = 1'b0;
            st++;
         end else begin
            bus.req_rdy_out_data[r] = (b < OUT);
         end
         if (b == rst_at) begin
            bus.arr_en_out_data     = 1'b0;
            bus.req_rdy_out_data[r] = 1'b0;
            rst = 1'b1;
            smp();
            break;
         end
         smp();
      end
      if (rst_at < 0) begin
         chk("beats", b, OUT);
         chk("sb_empty", sb.size(), 0);
      end
   endtask

   task automatic flush_check(input int r, input logic [1:0] nr);
      chk("jd_pulse", job_done, oh(r));
      chk("flush_rstn0", bus.arr_rstn, 0);
      chk("flush_grant0", grant, oh(r));
      chk("flush_ardy0", bus.arr_rdy_out_data, 0);
      adv();
      drive_req(nr);
      smp();
      chk("jd_one_cycle", job_done, 0);
      chk("flush_rstn1", bus.arr_rstn, 0);
      chk("flush_grant1", grant, oh(r));
      chk("flush_rdy_in", bus.req_rdy_in_data, 0);
      adv();
      smp();
      chk("idle_rstn", bus.arr_rstn, 1);
      chk("idle_grant", grant, 0);
      chk("idle_quiet", {bus.req_rdy_in_data, bus.req_en_out_data, bus.arr_en_in_data, bus.arr_rdy_out_data}, 0);
   endtask

   initial begin
      int c;
      rst = 1'b1;
      bus.req_en_in_data   = '0;
      bus.req_in_mat       = '0;
      bus.req_in_new_row   = '0;
      bus.req_in_mat_done  = '0;
      bus.req_in_data      = '0;
      bus.req_rdy_out_data = '0;
      bus.arr_rdy_in_data  = 1'b1;
      bus.arr_en_out_data  = 1'b0;
      bus.arr_out_data     = '0;
      repeat (2) adv();
      smp();
      chk("rst_grant", grant, 0);
      chk("rst_jd", job_done, 0);
      chk("rst_rstn", bus.arr_rstn, 0);
      chk("rst_quiet", {bus.req_rdy_in_data, bus.req_en_out_data, bus.arr_en_in_data, bus.arr_rdy_out_data}, 0);
      adv();
      rst = 1'b0;
      smp();
      chk("post_rst_rstn", bus.arr_rstn, 1);
      chk("post_rst_grant", grant, 0);

      // Simultaneous requests straight out of reset: 0 first, 1 waits.
      raise(2'b11);
      wait_grant(0, c);
      chk("lat_both", c, 1);
      load(0);
      drain(0, -1, 0, -1);
      flush_check(0, 2'b00);
      wait_grant(1, c);
      chk("lat_r1", c, 1);
      load(1);
      drain(1, -1, 0, -1);
      flush_check(1, 2'b00);

      // Requester 0 alone, then three back-to-back jobs with the request held through flush.
      raise(2'b01);
      wait_grant(0, c);
      chk("lat_single", c, 1);
      load(0);
      drain(0, -1, 0, -1);
      flush_check(0, 2'b01);
      for (int i = 0; i < 3; i++) begin
         wait_grant(0, c);
         chk("lat_b2b", c, 1);
         load(0);
         drain(0, -1, 0, -1);
         flush_check(0, (i < 2) ? 2'b01 : 2'b00);
      end

      // Result backpressure for 5 cycles after beat 3.
      raise(2'b01);
      wait_grant(0, c);
      load(0);
      drain(0, 3, 5, -1);
      flush_check(0, 2'b00);

      // Reset during drain after 4 beats: job aborted, pointer back to 0.
      raise(2'b01);
      wait_grant(0, c);
      load(0);
      drain(0, -1, 0, 4);
      chk("abort_rstn", bus.arr_rstn, 0);
      adv();
      smp();
      chk("abort_grant", grant, 0);
      chk("abort_jd", job_done, 0);
      chk("abort_en_out", bus.req_en_out_data, 0);
      adv();
      rst = 1'b0;
      sb.delete();
      smp();
      chk("abort_rstn_up", bus.arr_rstn, 1);
      chk("abort_jd2", job_done, 0);
      raise(2'b11);
      wait_grant(0, c);
      chk("abort_ptr", c, 1);
      load(0);
      drain(0, -1, 0, -1);
      flush_check(0, 2'b00);
      wait_grant(1, c);
      load(1);
      drain(1, -1, 0, -1);
      flush_check(1, 2'b00);

      // Requester 1 arrives while 0 owns the array.
      raise(2'b01);
      wait_grant(0, c);
      drive_req(2'b10);
      load(0);
      drain(0, -1, 0, -1);
      flush_check(0, 2'b00);
      wait_grant(1, c);
      chk("late_r1_lat", c, 1);
      load(1);
      drain(1, -1, 0, -1);
      flush_check(1, 2'b00);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end
endmodule
